adder_trojan_test_sequencer: RTL
================================

Name: adder_trojan_test_sequencer

Overview:
- Sequential controller that exhaustively exercises an external WIDTH-bit ripple-carry adder under test.
- Drives every {a, b, cin} combination, one per cycle, and compares each response against an internal golden sum.
- Reports mismatch count and the first failing vector.
- Sits between the trojan-detection test harness and the adder netlist instance. It is the block that sequences the adder datapath.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- RESP_LAT, 1, cycles from pattern drive to response sample. Legal range 1..8.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a test run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- dut_a  out  WIDTH  operand a to the adder under test.
- dut_b  out  WIDTH  operand b to the adder under test.
- dut_cin  out  1  carry-in to the adder under test.
- dut_sum  in  WIDTH  sum returned by the adder under test.
- dut_cout  in  1  carry-out returned by the adder under test.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  1 when the last completed run had zero mismatches.
- fail_count  out  2*WIDTH+2  number of mismatching patterns.
- first_fail_vec  out  2*WIDTH+1  {a,b,cin} of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset: synchronous, active-low on rst_n, applied on the clk edge. Reset overrides everything and can occur mid-run.
  - FSM goes to IDLE.
  - All outputs are 0: dut_a, dut_b, dut_cin, busy, done, pass, fail_count, first_fail_vec, first_fail_valid.
  - Delay pipeline is cleared.
- Pattern index: idx has 2*WIDTH+1 bits; N = 2^(2*WIDTH+1).
  - Mapping: dut_a = idx[2W:W+1], dut_b = idx[W:1], dut_cin = idx[0].
  - Operands are registered outputs.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - dut_* held at 0.
  - start=1 and abort=0 at edge k:
    - clear fail_count, first_fail_vec, first_fail_valid and pass;
    - set idx=0;
    - go to RUN.
  - Pattern 0 is visible on dut_* during cycle k+1.
- RUN:
  - Drive idx each cycle, then increment.
  - When idx=N-1 has been driven, go to DRAIN. idx never wraps.
- DRAIN:
  - Lasts RESP_LAT cycles.
  - dut_* hold the last pattern.
  - Comparisons continue during this state.
- DONE:
  - One cycle: done=1; pass = (fail_count==0).
  - Then return to IDLE.
- Compare path:
  - A shift register of depth RESP_LAT carries the driven pattern plus a valid bit.
  - At each cycle with delayed valid=1, golden = a + b + cin, computed WIDTH+1 bits wide. Compare it with {dut_cout, dut_sum}.
  - On mismatch: fail_count increments. If first_fail_valid=0, capture the delayed pattern into first_fail_vec and set first_fail_valid.
  - fail_count is wide enough for N and never saturates within a run.
- Timing: with start accepted at edge 0, the last compare is at edge N+RESP_LAT and done is high in cycle N+RESP_LAT+1. For WIDTH=4, RESP_LAT=1: done in cycle 514.
- start while busy or in DONE: ignored.
- abort in RUN or DRAIN:
  - Go to IDLE at the next edge; busy drops.
  - No done pulse; pass stays 0.
  - fail_count and first_fail_* keep their partial values.
  - Delay pipeline valid bits are flushed.
- start and abort both high in IDLE: abort wins; remain in IDLE.
- Result outputs hold their values until the next accepted start or reset.

Decomposition:
- Shared package adder_test_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the localparam widths IDX_W = 2*WIDTH+1 and CNT_W = 2*WIDTH+2;
  - a golden-sum function.
- One sub-module, adder_resp_delay: RESP_LAT-deep valid+pattern shift register with synchronous flush.

Test Plan:
- Correct adder, WIDTH=4, RESP_LAT=1 -> done pulse in cycle 514; fail_count=0; pass=1; first_fail_valid=0.
- Adder with carry into stage 2 forced to 1 (trojan at node C2) -> fail_count=256; first_fail_vec=0; first_fail_valid=1; pass=0.
- dut_cout stuck at 0 -> fail_count=256; first_fail_vec=31 (a=0, b=15, cin=1).
- RESP_LAT=2, correct adder with a 2-cycle registered response -> done in cycle 515; pass=1.
- Fault case above with abort asserted at cycle 100 -> busy low at cycle 101; no done pulse; fail_count < 256 and held; then start in the same run -> counters cleared and a full run completes normally.
- rst_n low for one cycle at cycle 300 mid-run -> all outputs 0 next cycle; FSM in IDLE; start asserted together with abort in IDLE -> no run starts.

Source files
------------

// File: rtl/adder_test_pkg.sv
// Shared types, widths and the golden-sum reference for the adder test sequencer.
package adder_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default operand width and the widths derived from it.
    localparam int DEF_WIDTH = 4;
    localparam int IDX_W     = 2 * DEF_WIDTH + 1;
    localparam int CNT_W     = 2 * DEF_WIDTH + 2;

    // Widest operand the golden-sum helper accepts.
    localparam int MAX_WIDTH = 16;

    // Pattern index / failure counter widths for an arbitrary operand width.
    function automatic int idx_width(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int cnt_width(input int width);
        return 2 * width + 2;
    endfunction

    // Reference sum a + b + cin, one bit wider than the operands.
    function automatic logic [MAX_WIDTH:0] golden_sum(input logic [MAX_WIDTH-1:0] a,
                                                      input logic [MAX_WIDTH-1:0] b,
                                                      input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_trojan_test_sequencer_if.sv
// Operand/response bus between the test sequencer and the adder under test.
interface adder_trojan_test_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;

    // The sequencer drives operands and samples the response.
    modport master (output dut_a, output dut_b, output dut_cin,
                    input  dut_sum, input dut_cout);

    // The adder under test consumes operands and returns the response.
    modport slave  (input  dut_a, input dut_b, input dut_cin,
                    output dut_sum, output dut_cout);
endinterface

// File: rtl/adder_resp_delay.sv
// DEPTH-deep valid+pattern shift register aligning driven patterns with responses.
module adder_resp_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][DW-1:0] data_q,  data_d;

    // Shift one stage per cycle; a flush drops every in-flight valid bit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = DEPTH - 1; i > 0; i--) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        if (flush) begin
            valid_d = '0;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the pattern storage is cleared too, so a reset leaves no stale vector behind.
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignment so all stages update from pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/adder_trojan_test_sequencer.sv
// Exhaustive stimulus/compare sequencer for an external ripple-carry adder.
module adder_trojan_test_sequencer
    import adder_test_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,  // at most MAX_WIDTH
    parameter int RESP_LAT = 1           // 1..8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    adder_trojan_test_sequencer_if.master bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [2*WIDTH+1:0]           fail_count,
    output logic [2*WIDTH:0]             first_fail_vec,
    output logic                         first_fail_valid
);
    localparam int IW = idx_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              cin_q, cin_d;
    logic [2:0]        drain_q, drain_d;
    logic              done_q, done_d, pass_q, pass_d;
    logic [CW-1:0]     fail_q, fail_d;
    logic [IW-1:0]     ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;

    logic              push, flush;
    logic              dly_valid;
    logic [IW-1:0]     dly_vec;
    logic [WIDTH:0]    golden;

    adder_resp_delay #(.DEPTH(RESP_LAT), .DW(IW)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (push),
        .in_data  (idx_q),
        .out_valid(dly_valid),
        .out_data (dly_vec)
    );

    // Golden sum of the pattern whose response is arriving this cycle.
    assign golden = (WIDTH+1)'(golden_sum(MAX_WIDTH'(dly_vec[2*WIDTH:WIDTH+1]),
                                          MAX_WIDTH'(dly_vec[WIDTH:1]),
                                          dly_vec[0]));

    // Next-state, operand drive and result bookkeeping.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        push      = 1'b0;
        flush     = 1'b0;

        if (dly_valid && (golden != {bus.dut_cout, bus.dut_sum})) begin
            fail_d = fail_q + CW'(1);
            if (!ffvalid_q) begin
                ffv_d     = dly_vec;
                ffvalid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                {a_d, b_d, cin_d} = '0;
                if (start && !abort) begin
                    fail_d    = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    {a_d, b_d, cin_d} = '0;
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    {a_d, b_d, cin_d} = idx_q;
                    push = 1'b1;
                    if (idx_q == '1) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    {a_d, b_d, cin_d} = '0;
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (drain_q == 3'(RESP_LAT - 1)) begin
                    done_d  = 1'b1;
                    pass_d  = (fail_d == '0);
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE: begin
                {a_d, b_d, cin_d} = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign bus.dut_a        = a_q;
    assign bus.dut_b        = b_q;
    assign bus.dut_cin      = cin_q;
    assign busy             = (state_q == RUN) || (state_q == DRAIN);
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;
endmodule
